base_ram_arbiter: RTL and testbench



---
 rtl/base_ram_arbiter.sv | 154 +++++++++++++++
 tb/tb_base_ram_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/base_ram_arbiter.sv
// rtl/base_ram_arbiter.sv - Shares BaseRAM between fetch and data ports through a registered multi-cycle access FSM.
module base_ram_arbiter #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk_50M,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_sel_n,
    output logic [31:0] mem_rdata,
    output logic        mem_ack,
    output logic        busy,
    inout  wire  [31:0] base_ram_data,
    output logic [19:0] base_ram_addr,
    output logic [3:0]  base_ram_be_n,
    output logic        base_ram_ce_n,
    output logic        base_ram_oe_n,
    output logic        base_ram_we_n
);

    typedef enum logic [2:0] {IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, ACK} state_t;

    localparam logic [2:0] LAST = 3'(WAIT_CYCLES);

    state_t      state, state_d;
    logic [2:0]  cnt, cnt_d;
    logic        grant_mem, grant_mem_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] wdata_q;
    logic        drive_q;
    logic        ce_d, oe_d, we_d, drive_d;
    logic [3:0]  be_d;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^{if_addr[31:22], if_addr[1:0], mem_addr[31:22], mem_addr[1:0]};
    assign base_ram_data = drive_q ? wdata_q : 32'bz;

    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        grant_mem_d = grant_mem;
        sel_d       = sel_q;
        case (state)
            IDLE: begin
                if (mem_req) begin
                    grant_mem_d = 1'b1;
                    sel_d       = mem_sel_n;
                    state_d     = mem_we ? WR_SETUP : RD;
                end else if (if_req) begin
                    grant_mem_d = 1'b0;
                    state_d     = RD;
                end
            end
            RD: begin
                if (cnt == LAST) begin
                    cnt_d   = 3'd0;
                    state_d = ACK;
                end else begin
                    cnt_d = cnt + 3'd1;
                end
            end
            WR_SETUP: state_d = WR_PULSE;
            WR_PULSE: begin
                if (cnt == LAST) begin
                    cnt_d   = 3'd0;
                    state_d = WR_HOLD;
                end else begin
                    cnt_d = cnt + 3'd1;
                end
            end
            WR_HOLD: state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Pin values are decoded from the next state so they land in registers.
        ce_d    = 1'b1;
        oe_d    = 1'b1;
        we_d    = 1'b1;
        be_d    = 4'b1111;
        drive_d = 1'b0;
        case (state_d)
            RD: begin
                ce_d = 1'b0;
                oe_d = 1'b0;
                be_d = 4'b0000;
            end
            WR_SETUP, WR_HOLD: begin
                ce_d    = 1'b0;
                be_d    = sel_d;
                drive_d = 1'b1;
            end
            WR_PULSE: begin
                ce_d    = 1'b0;
                we_d    = 1'b0;
                be_d    = sel_d;
                drive_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= 3'd0;
            grant_mem     <= 1'b0;
            sel_q         <= 4'b1111;
            wdata_q       <= 32'd0;
            drive_q       <= 1'b0;
            busy          <= 1'b0;
            if_ack        <= 1'b0;
            mem_ack       <= 1'b0;
            if_rdata      <= 32'd0;
            mem_rdata     <= 32'd0;
            base_ram_addr <= 20'd0;
            base_ram_be_n <= 4'b1111;
            base_ram_ce_n <= 1'b1;
            base_ram_oe_n <= 1'b1;
            base_ram_we_n <= 1'b1;
        end else begin
            state         <= state_d;
            cnt           <= cnt_d;
            grant_mem     <= grant_mem_d;
            sel_q         <= sel_d;
            drive_q       <= drive_d;
            busy          <= (state_d != IDLE);
            if_ack        <= (state_d == ACK) && !grant_mem_d;
            mem_ack       <= (state_d == ACK) && grant_mem_d;
            base_ram_be_n <= be_d;
            base_ram_ce_n <= ce_d;
            base_ram_oe_n <= oe_d;
            base_ram_we_n <= we_d;
            if (state == IDLE && state_d != IDLE) begin
                base_ram_addr <= grant_mem_d ? mem_addr[21:2] : if_addr[21:2];
                wdata_q       <= mem_wdata;
            end
            if (state == RD && state_d == ACK) begin
                if (grant_mem) begin
                    mem_rdata <= base_ram_data;
                end else begin
                    if_rdata <= base_ram_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_base_ram_arbiter.sv
// tb/tb_base_ram_arbiter.sv - Bench for base_ram_arbiter at WAIT_CYCLES 0, 1 and 3 with SRAM models.
module tb_base_ram_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #10 clk = ~clk;

    logic [2:0]        if_req_v = 3'b000;
    logic [2:0]        mem_req_v = 3'b000;
    logic              mem_we = 1'b0;
    logic [31:0]       if_addr = 32'd0;
    logic [31:0]       mem_addr = 32'd0;
    logic [31:0]       mem_wdata = 32'd0;
    logic [3:0]        mem_sel_n = 4'hF;
    logic [2:0]        if_ack_v, mem_ack_v, busy_v, ce_n_v, oe_n_v, we_n_v;
    logic [2:0][31:0]  if_rdata_v, mem_rdata_v, bus_v;
    logic [2:0][19:0]  addr_v;
    logic [2:0][3:0]   be_v;

    int checks = 0;
    int failures = 0;

    function automatic int wv(int g);
        return (g == 0) ? 0 : ((g == 1) ? 1 : 3);
    endfunction

    function automatic logic [31:0] init_val(int i);
        if (i == 4) return 32'h3C011234;
        if (i == 12) return 32'h11223344;
        return {8'hA5, 8'(i), 8'(i * 3), 8'(i * 7)};
    endfunction

    for (genvar g = 0; g < 3; g++) begin : u
        wire  [31:0] bus;
        logic [31:0] ram [64];
        logic [19:0] a;
        logic [3:0]  be;
        logic        ce, oe, we, ifa, mema, bsy;
        logic [31:0] ifr, memr;

        base_ram_arbiter #(.WAIT_CYCLES((g == 0) ? 0 : ((g == 1) ? 1 : 3))) dut (
            .clk_50M(clk), .rst_n(rst_n),
            .if_req(if_req_v[g]), .if_addr(if_addr), .if_rdata(ifr), .if_ack(ifa),
            .mem_req(mem_req_v[g]), .mem_we(mem_we), .mem_addr(mem_addr),
            .mem_wdata(mem_wdata), .mem_sel_n(mem_sel_n), .mem_rdata(memr), .mem_ack(mema),
            .busy(bsy), .base_ram_data(bus), .base_ram_addr(a), .base_ram_be_n(be),
            .base_ram_ce_n(ce), .base_ram_oe_n(oe), .base_ram_we_n(we));

        assign bus = (!ce && !oe) ? ram[a[5:0]] : 32'bz;

        initial for (int i = 0; i < 64; i++) ram[i] = init_val(i);

        always @(negedge clk) begin
            if (!ce && !we) begin
                for (int b = 0; b < 4; b++) begin
                    if (!be[b]) ram[a[5:0]][8*b +: 8] <= bus[8*b +: 8];
                end
            end
        end

        assign if_ack_v[g]    = ifa;
        assign mem_ack_v[g]   = mema;
        assign busy_v[g]      = bsy;
        assign ce_n_v[g]      = ce;
        assign oe_n_v[g]      = oe;
        assign we_n_v[g]      = we;
        assign if_rdata_v[g]  = ifr;
        assign mem_rdata_v[g] = memr;
        assign bus_v[g]       = bus;
        assign addr_v[g]      = a;
        assign be_v[g]        = be;
    end

    logic [31:0] ref_mem [64];
    logic [31:0] exp_if_rd, exp_mem_rd;

    function automatic void ref_write(int w, logic [31:0] d, logic [3:0] sel);
        for (int b = 0; b < 4; b++) begin
            if (!sel[b]) ref_mem[w][8*b +: 8] = d[8*b +: 8];
        end
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    int          if_at [3];
    int          mem_at [3];
    logic [15:0] we_mask, drv_mask;
    logic [3:0]  be_c2;
    logic [19:0] addr_c1;

    task automatic access(input bit do_if, input bit do_mem, input logic we, input logic [31:0] ia,
                          input logic [31:0] ma, input logic [31:0] wd, input logic [3:0] sel,
                          input string tag);
        bit done;
        @(posedge clk);
        #1;
        if_addr = ia; mem_addr = ma; mem_wdata = wd; mem_sel_n = sel; mem_we = we;
        if_req_v  = do_if ? 3'b111 : 3'b000;
        mem_req_v = do_mem ? 3'b111 : 3'b000;
        we_mask = '0; drv_mask = '0; be_c2 = 4'h0; addr_c1 = '0;
        for (int g = 0; g < 3; g++) begin
            if_at[g] = -1;
            mem_at[g] = -1;
        end
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (c < 16) begin
                we_mask[c]  = !we_n_v[1];
                drv_mask[c] = oe_n_v[1] && (bus_v[1] === wd);
            end
            if (c == 1) addr_c1 = addr_v[1];
            if (c == 2) be_c2 = be_v[1];
            for (int g = 0; g < 3; g++) begin
                if (if_ack_v[g] && if_at[g] < 0) if_at[g] = c;
                if (mem_ack_v[g] && mem_at[g] < 0) mem_at[g] = c;
            end
            @(posedge clk);
            #1;
            for (int g = 0; g < 3; g++) begin
                if (if_at[g] >= 0) if_req_v[g] = 1'b0;
                if (mem_at[g] >= 0) mem_req_v[g] = 1'b0;
            end
            done = (if_req_v == 3'b000) && (mem_req_v == 3'b000);
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL %s_timeout: actual=pending_req required=all_acked", tag);
            if_req_v = 3'b000;
            mem_req_v = 3'b000;
        end
    endtask

    typedef struct {
        bit          do_if;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        logic [31:0] exp_rd;
        int          exp_ack;
        logic [15:0] exp_we_mask;
        logic [15:0] exp_drv_mask;
        logic [3:0]  exp_be_c2;
        logic [19:0] exp_addr_c1;
    } vec_t;

    vec_t vecs [7];

    initial begin
        #1000000;
        $display("FAIL watchdog: actual=no_finish required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat, w;
        int          kind;
        bit          r_if, r_mem, r_we;
        logic [5:0]  iw, mw;
        logic [31:0] r, wd;
        logic [3:0]  sel;
        logic [2:0]  ack_seen, busy_seen;

        vecs[0] = '{1'b1, 1'b0, 32'h80000010, 32'hFFFF0000, 4'hF, 32'h3C011234, 3, 16'h0000, 16'h0000, 4'b0000, 20'd4};
        vecs[1] = '{1'b0, 1'b1, 32'h80000020, 32'hDEADBEEF, 4'h0, 32'h00000000, 5, 16'h000C, 16'h001E, 4'b0000, 20'd8};
        vecs[2] = '{1'b0, 1'b0, 32'h80000020, 32'hFFFF0000, 4'hF, 32'hDEADBEEF, 3, 16'h0000, 16'h0000, 4'b0000, 20'd8};
        vecs[3] = '{1'b0, 1'b1, 32'h80000030, 32'h000000AA, 4'hE, 32'h00000000, 5, 16'h000C, 16'h001E, 4'b1110, 20'd12};
        vecs[4] = '{1'b0, 1'b0, 32'h80000030, 32'hFFFF0000, 4'hF, 32'h112233AA, 3, 16'h0000, 16'h0000, 4'b0000, 20'd12};
        vecs[5] = '{1'b1, 1'b0, 32'h80000020, 32'hFFFF0000, 4'hF, 32'hDEADBEEF, 3, 16'h0000, 16'h0000, 4'b0000, 20'd8};
        vecs[6] = '{1'b0, 1'b0, 32'hFFC00030, 32'hFFFF0000, 4'hF, 32'h112233AA, 3, 16'h0000, 16'h0000, 4'b0000, 20'd12};

        for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);

        repeat (3) @(posedge clk);
        #5;
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("rst_if_ack_w%0d", wv(g)), if_ack_v[g], 1'b0);
            chk($sformatf("rst_mem_ack_w%0d", wv(g)), mem_ack_v[g], 1'b0);
            chk($sformatf("rst_busy_w%0d", wv(g)), busy_v[g], 1'b0);
            chk($sformatf("rst_addr_w%0d", wv(g)), addr_v[g], 20'd0);
            chk($sformatf("rst_be_w%0d", wv(g)), be_v[g], 4'hF);
            chk($sformatf("rst_ctl_w%0d", wv(g)), {ce_n_v[g], oe_n_v[g], we_n_v[g]}, 3'b111);
            chk($sformatf("rst_rdata_w%0d", wv(g)), {if_rdata_v[g], mem_rdata_v[g]}, 64'd0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_if_rd = 32'd0;
        exp_mem_rd = 32'd0;

        for (int v = 0; v < 7; v++) begin
            access(vecs[v].do_if, !vecs[v].do_if, vecs[v].we, vecs[v].addr, vecs[v].addr,
                   vecs[v].wdata, vecs[v].sel, $sformatf("vec%0d", v));
            if (vecs[v].we) ref_write(int'(vecs[v].addr[7:2]), vecs[v].wdata, vecs[v].sel);
            else if (vecs[v].do_if) exp_if_rd = vecs[v].exp_rd;
            else exp_mem_rd = vecs[v].exp_rd;
            chk($sformatf("vec%0d_ack_cycle", v), vecs[v].do_if ? if_at[1] : mem_at[1], vecs[v].exp_ack);
            chk($sformatf("vec%0d_we_low_cycles", v), we_mask, vecs[v].exp_we_mask);
            chk($sformatf("vec%0d_bus_drive_cycles", v), drv_mask, vecs[v].exp_drv_mask);
            chk($sformatf("vec%0d_be_n", v), be_c2, vecs[v].exp_be_c2);
            chk($sformatf("vec%0d_addr", v), addr_c1, vecs[v].exp_addr_c1);
            for (int g = 0; g < 3; g++) begin
                lat = (vecs[v].we ? 4 : 2) + wv(g);
                chk($sformatf("vec%0d_lat_w%0d", v, wv(g)), vecs[v].do_if ? if_at[g] : mem_at[g], lat);
                chk($sformatf("vec%0d_if_rdata_w%0d", v, wv(g)), if_rdata_v[g], exp_if_rd);
                chk($sformatf("vec%0d_mem_rdata_w%0d", v, wv(g)), mem_rdata_v[g], exp_mem_rd);
            end
        end

        access(1'b1, 1'b1, 1'b0, 32'h80000010, 32'h80000020, 32'hFFFF0000, 4'hF, "simul");
        exp_if_rd = 32'h3C011234;
        exp_mem_rd = 32'hDEADBEEF;
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("simul_mem_first_w%0d", wv(g)), mem_at[g], 2 + wv(g));
            chk($sformatf("simul_if_gap_w%0d", wv(g)), if_at[g] - mem_at[g], 3 + wv(g));
            chk($sformatf("simul_if_rdata_w%0d", wv(g)), if_rdata_v[g], exp_if_rd);
            chk($sformatf("simul_mem_rdata_w%0d", wv(g)), mem_rdata_v[g], exp_mem_rd);
        end

        for (int n = 0; n < 40; n++) begin
            kind  = int'($urandom_range(0, 3));
            r_if  = (kind == 0) || (kind == 3);
            r_mem = (kind != 0);
            r_we  = r_mem && ($urandom_range(0, 1) == 1);
            iw    = 6'($urandom_range(0, 63));
            mw    = 6'($urandom_range(0, 63));
            wd    = $urandom;
            sel   = 4'($urandom_range(0, 15));
            r     = $urandom;
            access(r_if, r_mem, r_we, {r[31:22], 14'd0, iw, r[1:0]}, {r[21:12], 14'd0, mw, r[3:2]},
                   wd, sel, $sformatf("rnd%0d", n));
            if (r_mem) begin
                if (r_we) ref_write(int'(mw), wd, sel);
                else exp_mem_rd = ref_mem[mw];
            end
            if (r_if) exp_if_rd = ref_mem[iw];
            for (int g = 0; g < 3; g++) begin
                w = wv(g);
                lat = (r_we ? 4 : 2) + w;
                if (r_mem) chk($sformatf("rnd%0d_mem_lat_w%0d", n, w), mem_at[g], lat);
                if (r_if) chk($sformatf("rnd%0d_if_lat_w%0d", n, w), if_at[g], r_mem ? lat + 3 + w : 2 + w);
                chk($sformatf("rnd%0d_if_rdata_w%0d", n, w), if_rdata_v[g], exp_if_rd);
                chk($sformatf("rnd%0d_mem_rdata_w%0d", n, w), mem_rdata_v[g], exp_mem_rd);
            end
        end

        @(posedge clk);
        #1;
        mem_addr = 32'h80000050; mem_wdata = 32'h0BADF00D; mem_sel_n = 4'h0; mem_we = 1'b1;
        mem_req_v = 3'b111;
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("pre_reset_we_low", we_n_v, 3'b000);
        rst_n = 1'b0;
        #1;
        chk("async_rst_we_n", we_n_v, 3'b111);
        chk("async_rst_ce_n", ce_n_v, 3'b111);
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("async_rst_bus_released_w%0d", wv(g)), bus_v[g] === 32'h0BADF00D, 1'b0);
        end
        mem_req_v = 3'b000;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ack_seen = 3'b000;
        busy_seen = 3'b000;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            ack_seen  = ack_seen | if_ack_v | mem_ack_v;
            busy_seen = busy_seen | busy_v;
        end
        chk("rst_no_ack", ack_seen, 3'b000);
        chk("rst_busy_after_release", busy_seen, 3'b000);
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("rst_rdata_cleared_w%0d", wv(g)), {if_rdata_v[g], mem_rdata_v[g]}, 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
